// File: rtl/core_fetch.sv
// core_fetch: instruction fetch stage issuing in-order imem reads, dropping stale responses after a redirect
// and buffering {pc, ir} pairs for decode.
module core_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] d_pc,
  output logic [31:0] d_ir,
  output logic        d_valid,
  input  logic        d_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  // stale responses can outnumber DEPTH across repeated redirects with slow memory
  localparam int KW = CW + 4;
  logic [31:0]   r_pc, r_tag;
  logic [CW-1:0] r_inflight, r_cnt;
  logic [KW-1:0] r_kill;
  logic [AW-1:0] r_rd, r_wr;
  logic [31:0]   r_fpc [DEPTH];
  logic [31:0]   r_fir [DEPTH];
  logic          w_pop, w_acc, w_live_rsp, w_kill_rsp, w_push;
  logic [CW:0]   w_used;
  logic [31:0]   w_redir_pc;
  logic [AW-1:0] w_rd_nxt, w_wr_nxt;

  assign w_pop          = d_valid & d_ready;
  assign w_used         = {1'b0, r_cnt} + {1'b0, r_inflight} - (CW+1)'(w_pop);
  assign imem_req_valid = ~rst & ~redirect_en & (w_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_acc          = imem_req_valid & imem_req_ready;
  assign w_live_rsp     = imem_rsp_valid & (r_kill == '0);
  assign w_kill_rsp     = imem_rsp_valid & (r_kill != '0);
  assign w_push         = w_live_rsp & ~redirect_en;
  assign w_redir_pc     = redirect_pc & ~32'h3;
  assign w_rd_nxt       = (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
  assign w_wr_nxt       = (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
  assign d_valid        = ~rst & (r_cnt != '0);
  assign d_pc           = r_fpc[r_rd];
  assign d_ir           = r_fir[r_rd];

  // r_tag tracks the PC of the oldest live response, independent of how far r_pc has run ahead
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_tag      <= RESET_PC;
      r_inflight <= '0;
      r_kill     <= '0;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
    end else begin
      r_pc       <= redirect_en ? w_redir_pc : w_acc ? r_pc + 32'd4 : r_pc;
      r_tag      <= redirect_en ? w_redir_pc : w_push ? r_tag + 32'd4 : r_tag;
      r_inflight <= redirect_en ? '0 : r_inflight + CW'(w_acc) - CW'(w_live_rsp);
      r_kill     <= redirect_en ? r_kill + KW'(r_inflight) - KW'(imem_rsp_valid)
                                : r_kill - KW'(w_kill_rsp);
      r_cnt      <= redirect_en ? '0 : r_cnt + CW'(w_push) - CW'(w_pop);
      r_rd       <= redirect_en ? '0 : w_pop ? w_rd_nxt : r_rd;
      r_wr       <= redirect_en ? '0 : w_push ? w_wr_nxt : r_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fpc[r_wr] <= r_tag;
      r_fir[r_wr] <= imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_core_fetch.sv
// tb_core_fetch: directed stimulus for core_fetch with a queue-based reference model and latency-programmable memory.
module tb_core_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst, redirect_en, d_ready, mem_ready;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, d_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, d_pc, d_ir;
  int          checks = 0, errors = 0, lat = 1, cyc = 0;
  bit          started = 0;

  typedef struct {logic [31:0] pc; logic [31:0] ir;} ent_t;
  typedef struct {logic [31:0] pc; bit live;} req_t;
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  ent_t        m_fifo[$];
  req_t        m_out[$];
  mreq_t       mq[$];
  logic [31:0] m_pc;

  assign imem_req_ready = mem_ready;

  core_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .d_pc(d_pc), .d_ir(d_ir), .d_valid(d_valid), .d_ready(d_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_A5A5;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (m_out[i]) if (m_out[i].live) n++;
    return n;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wait_dpc(input string n, input logic [31:0] e);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (d_valid === 1'b1) got = 1;
      else step();
    end
    if (got) chk(n, d_pc, e);
    else begin
      checks++;
      errors++;
      $display("FAIL %s: d_valid never rose, expected pc %h", n, e);
    end
    step();
  endtask

  always @(posedge clk) started <= 1'b1;

  // memory presents the oldest due response just after each edge
  always @(posedge clk) begin
    #1;
    imem_rsp_valid = mq.size() > 0 && mq[0].due <= cyc;
    imem_rsp_data  = mq.size() > 0 ? mem_data(mq[0].addr) : 32'h0;
  end

  always @(negedge clk) begin : cmp
    bit   ev, ep, er;
    req_t o;
    if (started) begin
      ev = !rst && m_fifo.size() > 0;
      ep = ev && d_ready;
      er = !rst && !redirect_en && (m_fifo.size() + live_cnt() - int'(ep) < DEPTH);
      chk("req_valid", imem_req_valid, 32'(er));
      if (er) chk("req_addr", imem_req_addr, m_pc);
      chk("d_valid", d_valid, 32'(ev));
      if (ev) begin
        chk("d_pc", d_pc, m_fifo[0].pc);
        chk("d_ir", d_ir, m_fifo[0].ir);
      end
      if (rst) begin
        m_fifo.delete();
        m_out.delete();
        m_pc = RESET_PC;
      end else begin
        if (ep) void'(m_fifo.pop_front());
        if (imem_rsp_valid) begin
          if (m_out.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: response with no request outstanding");
          end else begin
            o = m_out.pop_front();
            if (o.live && !redirect_en) m_fifo.push_back('{o.pc, imem_rsp_data});
          end
        end
        if (redirect_en) begin
          m_fifo.delete();
          foreach (m_out[i]) m_out[i].live = 0;
          m_pc = {redirect_pc[31:2], 2'b00};
        end else if (er && imem_req_ready) begin
          m_out.push_back('{m_pc, 1'b1});
          m_pc += 32'd4;
        end
      end
      if (rst) mq.delete();
      else begin
        if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
        if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});
      end
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit got;
    rst = 1; redirect_en = 0; redirect_pc = 0; d_ready = 1; mem_ready = 1;
    imem_rsp_valid = 0; imem_rsp_data = 0;
    step(); mid();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    step(); rst = 0; mid();
    chk("c0_req_valid", imem_req_valid, 1);
    chk("c0_addr", imem_req_addr, 32'h0);
    step(); mid();
    chk("c1_d_valid", d_valid, 0);
    chk("c1_addr", imem_req_addr, 32'h4);
    for (int k = 2; k < 10; k++) begin
      step(); mid();
      chk("stream_valid", d_valid, 1);
      chk("stream_pc", d_pc, 32'(4 * (k - 2)));
      if (k == 2) chk("ir0", d_ir, 32'hA5A5_A5A5);
    end
    step(); d_ready = 0; mid();
    chk("stall_pc", d_pc, 32'd32);
    chk("stall_req", imem_req_valid, 0);
    for (int k = 11; k < 16; k++) begin
      step(); mid();
      chk("stall_req", imem_req_valid, 0);
      chk("stall_pc", d_pc, 32'd32);
    end
    step(); d_ready = 1; mid();
    chk("rel_pc0", d_pc, 32'd32);
    chk("rel_addr", imem_req_addr, 32'd40);
    step(); mid(); chk("rel_pc1", d_pc, 32'd36);
    step(); mid(); chk("rel_pc2", d_pc, 32'd40);
    step(); lat = 3;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      got = m_fifo.size() == 0 && live_cnt() == 2;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL two_inflight: never reached, expected 2 live requests");
    end
    redirect_en = 1; redirect_pc = 32'h200;
    step(); redirect_en = 0;
    wait_dpc("redir_pc0", 32'h200);
    wait_dpc("redir_pc1", 32'h204);
    lat = 1;
    repeat (8) step();
    redirect_en = 1; redirect_pc = 32'h280; mid();
    chk("r4_pop_valid", d_valid, 1);
    step(); redirect_pc = 32'h300; mid();
    chk("r4b_req", imem_req_valid, 0);
    step(); redirect_en = 0; mid();
    chk("r4_n2_valid", d_valid, 0);
    chk("r4_n2_addr", imem_req_addr, 32'h300);
    step(); mid(); chk("r4_n3_valid", d_valid, 0);
    step(); mid();
    chk("r4_n4_valid", d_valid, 1);
    chk("r4_pc0", d_pc, 32'h300);
    step(); mid(); chk("r4_pc1", d_pc, 32'h304);
    step(); mid(); chk("r4_pc2", d_pc, 32'h308);
    step(); redirect_en = 1; redirect_pc = 32'h103;
    step(); redirect_en = 0; mid();
    chk("align_addr", imem_req_addr, 32'h100);
    repeat (4) step();
    redirect_en = 1; redirect_pc = 32'hFFFF_FFFC;
    step(); redirect_en = 0; mid();
    chk("top_addr", imem_req_addr, 32'hFFFF_FFFC);
    step(); mid();
    chk("wrap_req", imem_req_valid, 1);
    chk("wrap_addr", imem_req_addr, 32'h0);
    step(); mid(); chk("wrap_pc0", d_pc, 32'hFFFF_FFFC);
    step(); mid(); chk("wrap_pc1", d_pc, 32'h0);
    step(); lat = 3;
    repeat (3) step();
    d_ready = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = m_fifo.size() >= 1 && m_out.size() >= 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL full_inflight: never reached, expected buffered and in-flight entries");
    end
    rst = 1; mid();
    chk("rst6_d_valid", d_valid, 0);
    chk("rst6_req", imem_req_valid, 0);
    step(); rst = 0; d_ready = 1; lat = 1; mid();
    chk("rst6_n1_valid", d_valid, 0);
    chk("rst6_req1", imem_req_valid, 1);
    chk("rst6_addr", imem_req_addr, RESET_PC);
    wait_dpc("rst6_pc0", RESET_PC);
    wait_dpc("rst6_pc1", RESET_PC + 32'd4);
    for (int i = 0; i < 16; i++) begin
      step();
      mem_ready = (i % 3) != 1;
      d_ready = (i % 4) != 2;
    end
    step(); mem_ready = 1; d_ready = 1;
    repeat (6) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
